// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//
// Purpose:
//   Consumer side of the ALU condition flags. Holds the architectural NZCV
//   register, which is committed at writeback. Counts flag-setting
//   instructions that are still in flight. Stalls decode when a B.cond would
//   read flags that are not committed yet. When the single outstanding setter
//   commits in the same cycle, its flags are bypassed to the B.cond.
//   B.cond and CBZ are resolved into a branch decision that is registered
//   one cycle after the instruction is accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   issue_valid       instruction presented in decode
//   issue_setflags    instruction writes NZCV at writeback (ADDS/SUBS)
//   issue_cond        instruction is B.cond
//   issue_cbz         instruction is CBZ
//   cond_code[3:0]    ARM condition field for B.cond
//   cbz_zero          zero status of the CBZ operand
//   wb_valid          a flag-setting instruction commits this cycle
//   wb_nzcv[3:0]      committed flags {N,Z,C,V}
//   flush             kills all in-flight flag setters
//   stall             combinational; decode must hold the instruction
//   flags[3:0]        architectural NZCV
//   br_valid          registered; branch decision valid
//   br_taken          registered; branch taken
//   protocol_err      sticky error, cleared only by reset
// -----------------------------------------------------------------------------
module flag_branch_unit #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic       issue_setflags,
    input  logic       issue_cond,
    input  logic       issue_cbz,
    input  logic [3:0] cond_code,
    input  logic       cbz_zero,
    input  logic       wb_valid,
    input  logic [3:0] wb_nzcv,
    input  logic       flush,
    output logic       stall,
    output logic [3:0] flags,
    output logic       br_valid,
    output logic       br_taken,
    output logic       protocol_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_e;

    // Evaluates an ARM condition against an {N,Z,C,V} nibble.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        logic res;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond_e'(cc))
            CC_EQ:   res = z;
            CC_NE:   res = !z;
            CC_CS:   res = c;
            CC_CC:   res = !c;
            CC_MI:   res = n;
            CC_PL:   res = !n;
            CC_VS:   res = v;
            CC_VC:   res = !v;
            CC_HI:   res = c & !z;
            CC_LS:   res = !(c & !z);
            CC_GE:   res = (n == v);
            CC_LT:   res = (n != v);
            CC_GT:   res = !z & (n == v);
            CC_LE:   res = !(!z & (n == v));
            default: res = 1'b1;  // AL and NV are both always taken
        endcase
        return res;
    endfunction

    logic [CW-1:0] count_q, count_d;
    logic [3:0]    flags_q, flags_d;
    logic          br_valid_q, br_valid_d;
    logic          br_taken_q, br_taken_d;
    logic          perr_q, perr_d;

    logic          multi;
    logic          cond_hazard;
    logic          set_hazard;
    logic          accept;
    logic          inc;
    logic          dec;
    logic [3:0]    eval_flags;

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        multi = (issue_setflags & issue_cond) | (issue_setflags & issue_cbz) |
                (issue_cond & issue_cbz);

        // A B.cond may proceed with no setter outstanding, or with exactly one
        // that commits this very cycle (its flags are bypassed below).
        cond_hazard = issue_cond &&
                      ((count_q > CNT_ONE) || (count_q == CNT_ONE && !wb_valid));
        // A full tracker can still take a setter when one retires this cycle.
        set_hazard  = issue_setflags && (count_q == CNT_MAX) && !wb_valid;

        stall  = issue_valid && !flush && (cond_hazard || set_hazard);
        accept = issue_valid && !stall && !flush;

        // Malformed instructions are accepted but otherwise ignored.
        inc = accept && issue_setflags && !multi;
        dec = wb_valid && (count_q != '0);

        eval_flags = (count_q == CNT_ONE && wb_valid) ? wb_nzcv : flags_q;

        flags_d = flags_q;
        if (wb_valid) begin
            flags_d = wb_nzcv;
        end

        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (inc && !dec) begin
            count_d = count_q + CNT_ONE;
        end else if (dec && !inc) begin
            count_d = count_q - CNT_ONE;
        end

        br_valid_d = accept && !multi && (issue_cond || issue_cbz);
        br_taken_d = 1'b0;
        if (br_valid_d) begin
            br_taken_d = issue_cbz ? cbz_zero : cond_eval(cond_code, eval_flags);
        end

        perr_d = perr_q;
        if ((issue_valid && multi) || (wb_valid && count_q == '0)) begin
            perr_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            flags_q    <= 4'b0000;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            flags_q    <= flags_d;
            br_valid_q <= br_valid_d;
            br_taken_q <= br_taken_d;
            perr_q     <= perr_d;
        end
    end

    assign flags        = flags_q;
    assign br_valid     = br_valid_q;
    assign br_taken     = br_taken_q;
    assign protocol_err = perr_q;

endmodule
